mips_inst_encoder: RTL

- Encoder counterpart to the instruction decoder: takes field-level instruction requests (operation select plus register numbers and immediate) and assembles the 32-bit MIPS word.
- Supported set is R-type add/sub/and/or/slt, lw and sw.
- Encoded words are buffered in an internal FIFO and delivered, with a sequence number, over a valid/ready port to the instruction-memory loader or fetch side.

---
 rtl/mips_isa_pkg.sv | 35 +++
 rtl/mips_enc_fifo.sv | 55 +++++
 rtl/mips_inst_encoder.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions for the instruction encoder and decoder:
// op-select enum, opcode/funct constants and instruction field positions.
package mips_isa_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_SLT  = 3'd4,
    OP_LW   = 3'd5,
    OP_SW   = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;

  // Least-significant bit of each instruction field
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/mips_enc_fifo.sv
// Circular FIFO holding encoded words with their sequence numbers.
// The head entry is presented directly from storage and forced to zero when empty.
module mips_enc_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign full       = (count == (AW+1)'(DEPTH));
  assign head_valid = (count != '0);
  assign wr_en      = push && !full && !clr;
  assign rd_en      = pop && head_valid && !clr;
  assign head_data  = head_valid ? mem[rptr] : '0;

  // Payload storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; clr outranks push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

endmodule

// File: rtl/mips_inst_encoder.sv
// Assembles 32-bit MIPS words from field-level requests, tags each with a
// sequence number and queues them for the instruction-memory side.
module mips_inst_encoder
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [15:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal_op
);

  logic             full;
  logic             accept;
  logic             push;
  logic             pop;
  logic             is_rsvd;
  logic [SEQ_W-1:0] seq;
  logic [31:0]      enc_word;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             is_rtype;

  assign in_ready = !full && !clr;
  assign accept   = in_valid && in_ready;
  assign is_rsvd  = (op_e'(in_op) == OP_RSVD);
  assign push     = accept && !is_rsvd;
  assign pop      = out_valid && out_ready;

  // Opcode/funct selection for the requested operation
  always_comb begin
    opcode   = OPC_RTYPE;
    funct    = F_ADD;
    is_rtype = 1'b1;
    case (op_e'(in_op))
      OP_ADD:  funct = F_ADD;
      OP_SUB:  funct = F_SUB;
      OP_AND:  funct = F_AND;
      OP_OR:   funct = F_OR;
      OP_SLT:  funct = F_SLT;
      OP_LW:   begin opcode = OPC_LW; is_rtype = 1'b0; end
      OP_SW:   begin opcode = OPC_SW; is_rtype = 1'b0; end
      default: funct = F_ADD;
    endcase
  end

  // Field packing; rd/shamt only contribute to R-type words
  always_comb begin
    enc_word = (32'(opcode) << OPC_LSB) | (32'(in_rs) << RS_LSB) | (32'(in_rt) << RT_LSB);
    if (is_rtype) begin
      enc_word = enc_word | (32'(in_rd) << RD_LSB) | (32'(in_shamt) << SHAMT_LSB)
               | (32'(funct) << FUNCT_LSB);
    end else begin
      enc_word = enc_word | (32'(in_imm) << IMM_LSB);
    end
  end

  // Sequence counter advances only on real writes; illegal_op is sticky until clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq        <= '0;
      illegal_op <= 1'b0;
    end else if (clr) begin
      seq        <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (push) seq <= seq + 1'b1;
      if (accept && is_rsvd) illegal_op <= 1'b1;
    end
  end

  mips_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32 + SEQ_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .push       (push),
    .push_data  ({seq, enc_word}),
    .pop        (pop),
    .full       (full),
    .count      (count),
    .head_valid (out_valid),
    .head_data  ({out_seq, out_inst})
  );

endmodule
